mic1_io_sched: RTL

Memory-mapped I/O controller between the mic1 core's data-memory port, main memory and the UART pair. It decodes the I/O addresses, steers loads and stores either to main memory or to the UART, and buffers received bytes in a small RX FIFO. It also stalls the core by gating its run enable while a transmit is in flight. It replaces ad-hoc run/TX gating at SoC top level with one scheduled owner of the I/O resource.

---
 rtl/mic1_io_sched_if.sv | 22 ++
 rtl/mic1_io_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mic1_io_sched_if.sv
// Data-memory bus between the mic1 core, main memory and the I/O scheduler.
// The slave side is the scheduler; the master side is core plus main memory.
interface mic1_io_sched_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata_mem;
    logic [31:0] mem_rdata_core;
    logic        mem_ren;
    logic        mem_wen;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, mem_rdata_mem,
        input  mem_rdata_core, mem_ren, mem_wen
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_rdata_mem,
        output mem_rdata_core, mem_ren, mem_wen
    );
endinterface

// File: rtl/mic1_io_sched.sv
// Memory-mapped UART I/O scheduler for mic1: address decode, TX stall FSM, RX FIFO.
// Optional blocking RX reads (stall until a byte arrives) with MIC1_IO_BLOCKING_RX_EN.
module mic1_io_sched #(
    parameter int          RX_DEPTH     = 4,
    parameter logic [31:0] IO_DATA_ADDR = 32'hFFFFFFFD,
    parameter logic [31:0] IO_STAT_ADDR = 32'hFFFFFFFC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_in,
    output logic             core_run,
    mic1_io_sched_if.slave   bus,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy
);
    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

`ifdef MIC1_IO_BLOCKING_RX_EN
    typedef enum logic [1:0] {IDLE, TX_WAIT, TX_BUSY, RX_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, TX_WAIT, TX_BUSY} state_t;
`endif

    state_t state, state_d;

    logic [7:0]       fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             io_sel_q, io_sel_d;
    logic [31:0]      io_rdata_q, io_rdata_d;

    logic data_hit, stat_hit, io_hit;
    logic acc_rd, acc_wr, data_rd, stat_rd;
    logic tx_accept, ovf_clr;
    logic fifo_nonempty, fifo_full;
    logic fifo_push, fifo_pop, fifo_drop;
    logic rx_block, rx_bypass;
    logic unused_wdata;

    assign data_hit = (bus.mem_addr == IO_DATA_ADDR);
    assign stat_hit = (bus.mem_addr == IO_STAT_ADDR);
    assign io_hit   = data_hit | stat_hit;

    // core_run depends only on run_in and registered state, never on the bus.
    assign core_run = run_in & (state == IDLE);

    assign acc_rd    = bus.mem_read  & core_run;
    assign acc_wr    = bus.mem_write & core_run;
    assign data_rd   = acc_rd & data_hit;
    assign stat_rd   = acc_rd & stat_hit;
    assign tx_accept = acc_wr & data_hit;
    assign ovf_clr   = acc_wr & stat_hit & bus.mem_wdata[2];

    assign bus.mem_ren = acc_rd & ~io_hit;
    assign bus.mem_wen = acc_wr & ~io_hit;

    assign fifo_nonempty = (count != '0);
    assign fifo_full     = (count == CNT_W'(RX_DEPTH));

`ifdef MIC1_IO_BLOCKING_RX_EN
    // A byte arriving while a blocked (or just-blocking) read waits goes
    // straight to the core and never enters the FIFO.
    assign rx_block  = data_rd & ~fifo_nonempty & ~rx_done;
    assign rx_bypass = rx_done & ((data_rd & ~fifo_nonempty) | (state == RX_WAIT));
`else
    assign rx_block  = 1'b0;
    assign rx_bypass = 1'b0;
`endif

    assign fifo_pop  = data_rd & fifo_nonempty;
    assign fifo_push = rx_done & ~rx_bypass & (~fifo_full | fifo_pop);
    assign fifo_drop = rx_done & ~rx_bypass & fifo_full & ~fifo_pop;

    assign bus.mem_rdata_core = io_sel_q ? io_rdata_q : bus.mem_rdata_mem;

    assign unused_wdata = ^bus.mem_wdata[31:8];

    always_comb begin
        state_d    = state;
        io_sel_d   = 1'b0;
        io_rdata_d = '0;

        case (state)
            IDLE: begin
                if (tx_accept)
                    state_d = TX_WAIT;
                else if (rx_block) begin
`ifdef MIC1_IO_BLOCKING_RX_EN
                    state_d = RX_WAIT;
`endif
                end
            end
            TX_WAIT: if (tx_busy)  state_d = TX_BUSY;
            TX_BUSY: if (!tx_busy) state_d = IDLE;
`ifdef MIC1_IO_BLOCKING_RX_EN
            RX_WAIT: if (rx_done)  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        if (stat_rd) begin
            io_sel_d   = 1'b1;
            io_rdata_d = {29'b0, ovf, state != IDLE, fifo_nonempty};
        end else if (data_rd && fifo_nonempty) begin
            io_sel_d   = 1'b1;
            io_rdata_d = {24'b0, fifo_mem[rd_ptr]};
        end else if (rx_bypass) begin
            io_sel_d   = 1'b1;
            io_rdata_d = {24'b0, rx_data};
        end else if (data_rd && !rx_block) begin
            io_sel_d   = 1'b1;
            io_rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            state <= state_d;
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            // A dropping push beats a same-cycle clear.
            if (fifo_drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            tx_start <= tx_accept;
            if (tx_accept) tx_data <= bus.mem_wdata[7:0];
            io_sel_q <= io_sel_d;
            if (io_sel_d) io_rdata_q <= io_rdata_d;
        end
    end

    // FIFO storage holds data only and needs no reset.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rx_data;
    end
endmodule
